// File: rtl/mp_ooo_tag_ctrl.sv
// mp_ooo_tag_ctrl: sequencer/arbiter in front of the single-port tag SRAM.
// Clears the whole array after reset or flush, then round-robins the one RW
// port between lookups (reads) and fills (writes). SRAM controls are active low.
// Optional performance counters are enabled with `define MP_OOO_TAG_CTRL_PERF_EN.
module mp_ooo_tag_ctrl #(
  parameter int TAG_WIDTH = 24,
  parameter int IDX_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  output logic                 init_done,
  input  logic                 lkup_valid,
  input  logic [IDX_WIDTH-1:0] lkup_idx,
  output logic                 lkup_ready,
  output logic                 lkup_resp_valid,
  output logic [TAG_WIDTH-1:0] lkup_resp_tag,
  input  logic                 fill_valid,
  input  logic [IDX_WIDTH-1:0] fill_idx,
  input  logic [TAG_WIDTH-1:0] fill_tag,
  output logic                 fill_ready,
  output logic                 sram_csb,
  output logic                 sram_web,
  output logic [IDX_WIDTH-1:0] sram_addr,
  output logic [TAG_WIDTH-1:0] sram_din,
  input  logic [TAG_WIDTH-1:0] sram_dout
`ifdef MP_OOO_TAG_CTRL_PERF_EN
  ,
  output logic [31:0]          perf_lkup_cnt,
  output logic [31:0]          perf_fill_cnt,
  output logic [31:0]          perf_conflict_cnt
`endif
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [IDX_WIDTH-1:0] IDX_LAST = {IDX_WIDTH{1'b1}};
  localparam logic [IDX_WIDTH-1:0] IDX_ONE  = {{(IDX_WIDTH-1){1'b0}}, 1'b1};

  state_e               state_q, state_d;
  logic [IDX_WIDTH-1:0] sweep_cnt_q, sweep_cnt_d;
  logic                 rr_ptr_q, rr_ptr_d;
  logic                 lkup_resp_valid_q, lkup_resp_valid_d;
  logic                 lkup_grant, fill_grant, conflict;

  // Next-state, arbitration and SRAM port drive; reset forces the SRAM idle at once.
  always_comb begin
    state_d     = state_q;
    sweep_cnt_d = sweep_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    lkup_grant  = 1'b0;
    fill_grant  = 1'b0;
    conflict    = 1'b0;
    init_done   = 1'b0;
    sram_csb    = 1'b1;
    sram_web    = 1'b1;
    sram_addr   = '0;
    sram_din    = '0;
    case (state_q)
      ST_INIT: begin
        sram_csb  = 1'b0;
        sram_web  = 1'b0;
        sram_addr = sweep_cnt_q;
        if (flush) begin
          sweep_cnt_d = '0;
        end else begin
          sweep_cnt_d = sweep_cnt_q + IDX_ONE;
          if (sweep_cnt_q == IDX_LAST) begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        init_done = 1'b1;
        if (flush) begin
          state_d     = ST_INIT;
          sweep_cnt_d = '0;
        end else begin
          if (lkup_valid && fill_valid) begin
            conflict   = 1'b1;
            lkup_grant = ~rr_ptr_q;
            fill_grant = rr_ptr_q;
            rr_ptr_d   = ~rr_ptr_q;
          end else begin
            lkup_grant = lkup_valid;
            fill_grant = fill_valid;
          end
          if (fill_grant) begin
            sram_csb  = 1'b0;
            sram_web  = 1'b0;
            sram_addr = fill_idx;
            sram_din  = fill_tag;
          end else if (lkup_grant) begin
            sram_csb  = 1'b0;
            sram_addr = lkup_idx;
          end
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
    if (rst) begin
      sram_csb = 1'b1;
      sram_web = 1'b1;
    end
    lkup_resp_valid_d = lkup_grant;
  end

  // Controller state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= ST_INIT;
      sweep_cnt_q       <= '0;
      rr_ptr_q          <= 1'b0;
      lkup_resp_valid_q <= 1'b0;
    end else begin
      state_q           <= state_d;
      sweep_cnt_q       <= sweep_cnt_d;
      rr_ptr_q          <= rr_ptr_d;
      lkup_resp_valid_q <= lkup_resp_valid_d;
    end
  end

  assign lkup_ready      = lkup_grant;
  assign fill_ready      = fill_grant;
  assign lkup_resp_valid = lkup_resp_valid_q;
  assign lkup_resp_tag   = lkup_resp_valid_q ? sram_dout : '0;

`ifdef MP_OOO_TAG_CTRL_PERF_EN
  logic [31:0] perf_lkup_cnt_q, perf_lkup_cnt_d;
  logic [31:0] perf_fill_cnt_q, perf_fill_cnt_d;
  logic [31:0] perf_conflict_cnt_q, perf_conflict_cnt_d;

  // Saturating event counters, cleared whenever a flush restarts the array.
  always_comb begin
    perf_lkup_cnt_d     = perf_lkup_cnt_q;
    perf_fill_cnt_d     = perf_fill_cnt_q;
    perf_conflict_cnt_d = perf_conflict_cnt_q;
    if (flush) begin
      perf_lkup_cnt_d     = '0;
      perf_fill_cnt_d     = '0;
      perf_conflict_cnt_d = '0;
    end else begin
      if (lkup_grant && (perf_lkup_cnt_q != 32'hFFFF_FFFF)) begin
        perf_lkup_cnt_d = perf_lkup_cnt_q + 32'd1;
      end
      if (fill_grant && (perf_fill_cnt_q != 32'hFFFF_FFFF)) begin
        perf_fill_cnt_d = perf_fill_cnt_q + 32'd1;
      end
      if (conflict && (perf_conflict_cnt_q != 32'hFFFF_FFFF)) begin
        perf_conflict_cnt_d = perf_conflict_cnt_q + 32'd1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_lkup_cnt_q     <= '0;
      perf_fill_cnt_q     <= '0;
      perf_conflict_cnt_q <= '0;
    end else begin
      perf_lkup_cnt_q     <= perf_lkup_cnt_d;
      perf_fill_cnt_q     <= perf_fill_cnt_d;
      perf_conflict_cnt_q <= perf_conflict_cnt_d;
    end
  end

  assign perf_lkup_cnt     = perf_lkup_cnt_q;
  assign perf_fill_cnt     = perf_fill_cnt_q;
  assign perf_conflict_cnt = perf_conflict_cnt_q;
`endif

endmodule

// File: tb/tb_mp_ooo_tag_ctrl.sv
// tb_mp_ooo_tag_ctrl: directed bench for mp_ooo_tag_ctrl with a behavioural
// 16x24 single-port SRAM attached. Define MP_OOO_TAG_CTRL_PERF_EN to also
// exercise the performance counters.
module tb_mp_ooo_tag_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        init_done;
  logic        lkup_valid = 1'b0;
  logic [3:0]  lkup_idx = '0;
  logic        lkup_ready;
  logic        lkup_resp_valid;
  logic [23:0] lkup_resp_tag;
  logic        fill_valid = 1'b0;
  logic [3:0]  fill_idx = '0;
  logic [23:0] fill_tag = '0;
  logic        fill_ready;
  logic        sram_csb;
  logic        sram_web;
  logic [3:0]  sram_addr;
  logic [23:0] sram_din;
  logic [23:0] sram_dout;
`ifdef MP_OOO_TAG_CTRL_PERF_EN
  logic [31:0] perf_lkup_cnt;
  logic [31:0] perf_fill_cnt;
  logic [31:0] perf_conflict_cnt;
`endif

  int checks = 0;
  int passes = 0;

  mp_ooo_tag_ctrl #(.TAG_WIDTH(24), .IDX_WIDTH(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .init_done       (init_done),
    .lkup_valid      (lkup_valid),
    .lkup_idx        (lkup_idx),
    .lkup_ready      (lkup_ready),
    .lkup_resp_valid (lkup_resp_valid),
    .lkup_resp_tag   (lkup_resp_tag),
    .fill_valid      (fill_valid),
    .fill_idx        (fill_idx),
    .fill_tag        (fill_tag),
    .fill_ready      (fill_ready),
    .sram_csb        (sram_csb),
    .sram_web        (sram_web),
    .sram_addr       (sram_addr),
    .sram_din        (sram_din),
    .sram_dout       (sram_dout)
`ifdef MP_OOO_TAG_CTRL_PERF_EN
    ,
    .perf_lkup_cnt     (perf_lkup_cnt),
    .perf_fill_cnt     (perf_fill_cnt),
    .perf_conflict_cnt (perf_conflict_cnt)
`endif
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  // Behavioural SRAM: preloaded with non-zero garbage so the clear sweep matters.
  logic [23:0] mem [16];
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 24'hA50000 | 24'(i);
    sram_dout = 24'h0;
    forever begin
      @(posedge clk);
      if (!sram_csb) begin
        if (!sram_web) mem[sram_addr] <= sram_din;
        else           sram_dout      <= mem[sram_addr];
      end
    end
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compare one observed value with its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Drive all request inputs, then let combinational outputs settle.
  task automatic applyStimulus(input logic lv, input logic [3:0] li, input logic fv,
                               input logic [3:0] fi, input logic [23:0] ft, input logic fl);
    lkup_valid = lv;
    lkup_idx   = li;
    fill_valid = fv;
    fill_idx   = fi;
    fill_tag   = ft;
    flush      = fl;
    #1;
  endtask

  // Advance to just after the next rising edge.
  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  // Walk n clear-sweep cycles checking the SRAM writes and that nothing is granted.
  task automatic sweep_check(input int n);
    for (int i = 0; i < n; i++) begin
      checkOutput("sweep_csb", 32'(sram_csb), 0);
      checkOutput("sweep_web", 32'(sram_web), 0);
      checkOutput("sweep_addr", 32'(sram_addr), i);
      checkOutput("sweep_din", 32'(sram_din), 0);
      checkOutput("sweep_init_done", 32'(init_done), 0);
      checkOutput("sweep_lkup_ready", 32'(lkup_ready), 0);
      checkOutput("sweep_fill_ready", 32'(fill_ready), 0);
      next_cycle();
    end
  endtask

  initial begin
    // Reset values while rst is high.
    #1;
    checkOutput("rst_init_done", 32'(init_done), 0);
    checkOutput("rst_lkup_ready", 32'(lkup_ready), 0);
    checkOutput("rst_fill_ready", 32'(fill_ready), 0);
    checkOutput("rst_resp_valid", 32'(lkup_resp_valid), 0);
    checkOutput("rst_csb", 32'(sram_csb), 1);
    checkOutput("rst_web", 32'(sram_web), 1);

    // Both requesters waiting through reset and the whole first sweep.
    applyStimulus(1'b1, 4'd7, 1'b1, 4'd3, 24'hABCDEF, 1'b0);
    checkOutput("rst_req_csb", 32'(sram_csb), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    sweep_check(16);

    // First RUN cycle: conflict, lookup favoured.
    checkOutput("run_init_done", 32'(init_done), 1);
    checkOutput("c0_lkup_ready", 32'(lkup_ready), 1);
    checkOutput("c0_fill_ready", 32'(fill_ready), 0);
    checkOutput("c0_csb", 32'(sram_csb), 0);
    checkOutput("c0_web", 32'(sram_web), 1);
    checkOutput("c0_addr", 32'(sram_addr), 7);
    next_cycle();
    // Fill wins the second conflict; idx 7 read back as cleared.
    checkOutput("c1_resp_valid", 32'(lkup_resp_valid), 1);
    checkOutput("c1_resp_tag", 32'(lkup_resp_tag), 0);
    checkOutput("c1_lkup_ready", 32'(lkup_ready), 0);
    checkOutput("c1_fill_ready", 32'(fill_ready), 1);
    checkOutput("c1_web", 32'(sram_web), 0);
    checkOutput("c1_addr", 32'(sram_addr), 3);
    checkOutput("c1_din", 32'(sram_din), 32'h00ABCDEF);
    next_cycle();
    // Lookup of the just-filled index.
    applyStimulus(1'b1, 4'd3, 1'b1, 4'd3, 24'hABCDEF, 1'b0);
    checkOutput("c2_resp_valid", 32'(lkup_resp_valid), 0);
    checkOutput("c2_lkup_ready", 32'(lkup_ready), 1);
    checkOutput("c2_fill_ready", 32'(fill_ready), 0);
    checkOutput("c2_addr", 32'(sram_addr), 3);
    next_cycle();
    checkOutput("c3_resp_valid", 32'(lkup_resp_valid), 1);
    checkOutput("c3_resp_tag", 32'(lkup_resp_tag), 32'h00ABCDEF);
    checkOutput("c3_fill_ready", 32'(fill_ready), 1);
    checkOutput("c3_lkup_ready", 32'(lkup_ready), 0);
    applyStimulus(1'b0, 4'd0, 1'b0, 4'd0, 24'h0, 1'b0);
    next_cycle();
    // Idle: no grant, port deselected, response cleared.
    checkOutput("idle_resp_valid", 32'(lkup_resp_valid), 0);
    checkOutput("idle_resp_tag", 32'(lkup_resp_tag), 0);
    checkOutput("idle_csb", 32'(sram_csb), 1);
    checkOutput("idle_web", 32'(sram_web), 1);
`ifdef MP_OOO_TAG_CTRL_PERF_EN
    checkOutput("perf_conflict", perf_conflict_cnt, 4);
    checkOutput("perf_lkup", perf_lkup_cnt, 2);
    checkOutput("perf_fill", perf_fill_cnt, 2);
`endif

    // Fill only, then lookup only of the same index.
    applyStimulus(1'b0, 4'd0, 1'b1, 4'd5, 24'h123456, 1'b0);
    checkOutput("fo_fill_ready", 32'(fill_ready), 1);
    checkOutput("fo_lkup_ready", 32'(lkup_ready), 0);
    checkOutput("fo_addr", 32'(sram_addr), 5);
    checkOutput("fo_web", 32'(sram_web), 0);
    next_cycle();
    applyStimulus(1'b1, 4'd5, 1'b0, 4'd0, 24'h0, 1'b0);
    checkOutput("lo_lkup_ready", 32'(lkup_ready), 1);
    checkOutput("lo_fill_ready", 32'(fill_ready), 0);
    checkOutput("lo_web", 32'(sram_web), 1);
    next_cycle();

    // Flush in the cycle after an accepted lookup: response still delivered.
    applyStimulus(1'b1, 4'd5, 1'b0, 4'd0, 24'h0, 1'b1);
    checkOutput("fl_resp_valid", 32'(lkup_resp_valid), 1);
    checkOutput("fl_resp_tag", 32'(lkup_resp_tag), 32'h00123456);
    checkOutput("fl_lkup_ready", 32'(lkup_ready), 0);
    checkOutput("fl_csb", 32'(sram_csb), 1);
    checkOutput("fl_init_done", 32'(init_done), 1);
    next_cycle();
    applyStimulus(1'b0, 4'd0, 1'b0, 4'd0, 24'h0, 1'b0);
    checkOutput("fl_after_resp_valid", 32'(lkup_resp_valid), 0);
`ifdef MP_OOO_TAG_CTRL_PERF_EN
    checkOutput("perf_clr_conflict", perf_conflict_cnt, 0);
    checkOutput("perf_clr_lkup", perf_lkup_cnt, 0);
`endif
    sweep_check(6);
    // Flush during the sweep restarts it from index 0.
    applyStimulus(1'b0, 4'd0, 1'b0, 4'd0, 24'h0, 1'b1);
    checkOutput("fl_init_addr", 32'(sram_addr), 6);
    next_cycle();
    applyStimulus(1'b0, 4'd0, 1'b0, 4'd0, 24'h0, 1'b0);
    sweep_check(16);
    checkOutput("fl_run_init_done", 32'(init_done), 1);

    // Previously filled index 5 now reads as cleared.
    applyStimulus(1'b1, 4'd5, 1'b0, 4'd0, 24'h0, 1'b0);
    checkOutput("pf_lkup_ready", 32'(lkup_ready), 1);
    next_cycle();
    checkOutput("pf_resp_valid", 32'(lkup_resp_valid), 1);
    checkOutput("pf_resp_tag", 32'(lkup_resp_tag), 0);
    next_cycle();

    // Reset with a response in flight drops it immediately.
    checkOutput("ar_pre_resp_valid", 32'(lkup_resp_valid), 1);
    rst = 1'b1;
    applyStimulus(1'b0, 4'd0, 1'b0, 4'd0, 24'h0, 1'b0);
    checkOutput("ar_resp_valid", 32'(lkup_resp_valid), 0);
    checkOutput("ar_resp_tag", 32'(lkup_resp_tag), 0);
    checkOutput("ar_csb", 32'(sram_csb), 1);
    checkOutput("ar_web", 32'(sram_web), 1);
    checkOutput("ar_init_done", 32'(init_done), 0);
    next_cycle();
    rst = 1'b0;
    #1;
    sweep_check(9);

    // Reset at sweep index 9 aborts the sweep.
    rst = 1'b1;
    #1;
    checkOutput("sr_csb", 32'(sram_csb), 1);
    checkOutput("sr_web", 32'(sram_web), 1);
    checkOutput("sr_init_done", 32'(init_done), 0);
    next_cycle();
    rst = 1'b0;
    #1;
    sweep_check(16);
    checkOutput("sr_run_init_done", 32'(init_done), 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
